record_serializer: RTL and testbench
====================================

RECORD_SERIALIZER -- requirements
Module: record_serializer

Interface
REQ-001 Parameter DATA_WIDTH, 91, width of one record popped from the upstream show-ahead FIFO.
REQ-002 Parameter BEAT_WIDTH, 32, width of one outgoing beat.
REQ-003 Parameter NUM_BEATS, 3, beats per record; SHALL satisfy NUM_BEATS*BEAT_WIDTH >= DATA_WIDTH and NUM_BEATS >= 2.
REQ-004 Port clk  input  1  clock; all state on rising edge.
REQ-005 Port rstb  input  1  reset, asynchronous, active-low.
REQ-006 Port fifoEmpty  input  1  upstream FIFO empty flag.
REQ-007 Port fifoOut  input  DATA_WIDTH  upstream FIFO head record (show-ahead, valid whenever fifoEmpty=0).
REQ-008 Port fifoRead  output  1  pop strobe to upstream FIFO, combinational.
REQ-009 Port beatData  output  BEAT_WIDTH  current beat.
REQ-010 Port beatValid  output  1  beatData valid.
REQ-011 Port beatReady  input  1  downstream accepts beat this cycle.
REQ-012 Port beatLast  output  1  current beat is last beat of its record.

Function
REQ-013 FSM states IDLE and SEND; beat counter width $clog2(NUM_BEATS); record held in NUM_BEATS*BEAT_WIDTH shift register.
REQ-014 IDLE & fifoEmpty=0: fifoRead=1 that cycle; shift register loads fifoOut zero-extended in upper bits; counter <= 0; next state SEND.
REQ-015 fifoRead SHALL never be 1 while fifoEmpty=1 and SHALL be 1 for exactly one cycle per record.
REQ-016 SEND: beatValid=1; beatData = shift register bits [BEAT_WIDTH-1:0] (record LSB first); beatLast = (counter == NUM_BEATS-1).
REQ-017 SEND & beatReady & ~beatLast: shift register shifts right by BEAT_WIDTH (zero fill), counter increments.
REQ-018 SEND & beatReady & beatLast & fifoEmpty=0: fifoRead=1, load next record, counter <= 0, stay SEND (no bubble between records).
REQ-019 SEND & beatReady & beatLast & fifoEmpty=1: next state IDLE.
REQ-020 SEND & ~beatReady: beatData, beatValid, beatLast, counter held stable; fifoRead=0.
REQ-021 IDLE: beatValid=0, beatLast=0, beatData=0; beatReady ignored.
REQ-022 Latency: first beat valid the cycle after its pop; sustained throughput one beat per cycle with beatReady=1.

Reset
REQ-023 rstb=0: state IDLE, counter 0, shift register 0; beatValid=0, beatLast=0, beatData=0, fifoRead=0 (combinationally via IDLE with output gated by rstb).
REQ-024 Reset mid-record discards the remaining beats of the already-popped record; after release, behaviour per REQ-014.

Configuration
REQ-025 Macro RECORD_SERIALIZER_PARITY_EN defined: extra output port beatParity (1 bit) = XOR of beatData, 0 in IDLE and reset, valid with beatValid.
REQ-026 Macro undefined: port beatParity absent; all other behaviour identical.

Structure
REQ-027 Shared package correction_pkg holds defaults CORR_RECORD_WIDTH=91, CORR_BEAT_WIDTH=32, CORR_NUM_BEATS=3 and the FSM state enum (IDLE, SEND).
REQ-028 No sub-module; FSM, counter and shift register in one module.

Verification
REQ-029 Reset then fifoEmpty=1 for 20 cycles -> fifoRead=0, beatValid=0 throughout.
REQ-030 One record fifoOut={27'h5A5A5A5,32'hCAFEBABE,32'h12345678}, beatReady=1 -> beats 32'h12345678, 32'hCAFEBABE, 32'h05A5A5A5 on consecutive cycles, beatLast only on third, then IDLE.
REQ-031 Two records queued, beatReady=1 -> six consecutive valid beats, fifoRead pulses exactly on cycles 0 and 3, beatLast on beats 3 and 6.
REQ-032 beatReady=0 for 4 cycles during beat index 1 -> beatData holds 32'hCAFEBABE, fifoRead=0, resumes with beat 2 on release.
REQ-033 rstb asserted during beat index 1 -> beatValid=0 immediately; after release with fifoEmpty=0, new record popped and beat 0 presented next cycle.
REQ-034 With RECORD_SERIALIZER_PARITY_EN, beats 32'h00000001 and 32'h00000003 -> beatParity 1 then 0.

Source files
------------

// File: rtl/correction_pkg.sv
// Shared defaults and FSM state type for the record serializer.
//   CORR_RECORD_WIDTH : default width of one upstream record
//   CORR_BEAT_WIDTH   : default width of one outgoing beat
//   CORR_NUM_BEATS    : default beats per record
//   ser_state_t       : serializer FSM states (IDLE, SEND)
package correction_pkg;

  localparam int CORR_RECORD_WIDTH = 91;
  localparam int CORR_BEAT_WIDTH   = 32;
  localparam int CORR_NUM_BEATS    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/record_serializer.sv
// Record serializer: pops one record from a show-ahead FIFO and emits it as
// NUM_BEATS beats of BEAT_WIDTH bits, least-significant beat first, with
// back-to-back records streamed without a bubble.
//
// Ports
//   clk        : clock, all state on rising edge
//   rstb       : asynchronous active-low reset
//   fifoEmpty  : upstream FIFO empty flag
//   fifoOut    : upstream FIFO head record (valid when fifoEmpty=0)
//   fifoRead   : pop strobe to upstream FIFO (combinational)
//   beatData   : current beat, zero when no beat is valid
//   beatValid  : beatData valid
//   beatReady  : downstream accepts the beat this cycle
//   beatLast   : current beat is the last of its record
//   beatParity : XOR of beatData (only when RECORD_SERIALIZER_PARITY_EN is defined)
//
// Build option: define RECORD_SERIALIZER_PARITY_EN to add the beatParity port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no record held; pop the FIFO head as soon as it is non-empty
// SEND  | presenting beat[cnt] of the held record to the downstream
module record_serializer
  import correction_pkg::*;
#(
  parameter int DATA_WIDTH = CORR_RECORD_WIDTH,
  parameter int BEAT_WIDTH = CORR_BEAT_WIDTH,
  parameter int NUM_BEATS  = CORR_NUM_BEATS
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  fifoEmpty,
  input  logic [DATA_WIDTH-1:0] fifoOut,
  output logic                  fifoRead,
  output logic [BEAT_WIDTH-1:0] beatData,
  output logic                  beatValid,
  input  logic                  beatReady,
  output logic                  beatLast
`ifdef RECORD_SERIALIZER_PARITY_EN
  ,
  output logic                  beatParity
`endif
);

  localparam int SHIFT_W = NUM_BEATS * BEAT_WIDTH;
  localparam int CNT_W   = $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);

  if (NUM_BEATS < 2 || NUM_BEATS * BEAT_WIDTH < DATA_WIDTH) begin : g_bad_params
    $error("record_serializer: NUM_BEATS*BEAT_WIDTH must cover DATA_WIDTH and NUM_BEATS >= 2");
  end

  ser_state_t         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [SHIFT_W-1:0] shreg, shreg_d;
  logic               pop, valid, last;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    pop     = 1'b0;
    valid   = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          pop                     = 1'b1;
          shreg_d                 = '0;
          shreg_d[DATA_WIDTH-1:0] = fifoOut;
          cnt_d                   = '0;
          state_d                 = SEND;
        end
      end
      SEND: begin
        valid = 1'b1;
        last  = (cnt == LAST_IDX);
        if (beatReady) begin
          if (!last) begin
            shreg_d = shreg >> BEAT_WIDTH;
            cnt_d   = cnt + CNT_W'(1);
          end else if (!fifoEmpty) begin
            // Reload on the last beat so consecutive records stream gap-free.
            pop                     = 1'b1;
            shreg_d                 = '0;
            shreg_d[DATA_WIDTH-1:0] = fifoOut;
            cnt_d                   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rstb keeps the FIFO from being popped while reset is held,
  // even though the state register already forces IDLE.
  assign fifoRead  = pop & rstb;
  assign beatValid = valid & rstb;
  assign beatLast  = last & rstb;
  assign beatData  = beatValid ? shreg[BEAT_WIDTH-1:0] : '0;

`ifdef RECORD_SERIALIZER_PARITY_EN
  assign beatParity = ^beatData;
`endif

endmodule

// File: tb/tb_record_serializer.sv
module tb_record_serializer;

  localparam int DW = 91;
  localparam int BW = 32;
  localparam int NB = 3;

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
    logic          p;
    int            cyc;
  } obs_t;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          fifoEmpty = 1'b1;
  logic [DW-1:0] fifoOut = '0;
  logic          fifoRead;
  logic [BW-1:0] beatData;
  logic          beatValid;
  logic          beatReady = 1'b0;
  logic          beatLast;
  logic          par_act;
`ifdef RECORD_SERIALIZER_PARITY_EN
  logic          beatParity;
  assign par_act = beatParity;
`else
  assign par_act = ^beatData;
`endif

  record_serializer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW), .NUM_BEATS(NB)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .fifoEmpty (fifoEmpty),
    .fifoOut   (fifoOut),
    .fifoRead  (fifoRead),
    .beatData  (beatData),
    .beatValid (beatValid),
    .beatReady (beatReady),
    .beatLast  (beatLast)
`ifdef RECORD_SERIALIZER_PARITY_EN
    ,
    .beatParity(beatParity)
`endif
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [DW-1:0] fifo_q[$];
  beat_t         exp_q[$];
  obs_t          obs[$];
  int            pop_cyc[$];
  logic          cap_pop = 1'b0;
  logic          cap_hs = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifoEmpty = (fifo_q.size() == 0);
    fifoOut   = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_rec(input logic [DW-1:0] r);
    fifo_q.push_back(r);
    refresh();
  endtask

  // Per-cycle comparison against the abstract model: a beat is valid whenever
  // popped-but-unaccepted beats exist; a pop happens when the FIFO has data and
  // the serializer holds nothing, or is finishing its final beat this cycle.
  always @(negedge clk) begin
    logic exp_pop;
    cyc++;
    if (!rstb) begin
      chk("rst_fifoRead", fifoRead, 0);
      chk("rst_beatValid", beatValid, 0);
      chk("rst_beatLast", beatLast, 0);
      chk("rst_beatData", beatData, 0);
      cap_pop = 1'b0;
      cap_hs  = 1'b0;
    end else begin
      exp_pop = (fifo_q.size() != 0) &&
                (exp_q.size() == 0 || (exp_q.size() == 1 && beatReady));
      chk("fifoRead", fifoRead, exp_pop);
      if (fifoRead && fifoEmpty) chk("read_while_empty", 1, 0);
      chk("beatValid", beatValid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("beatData", beatData, exp_q[0].d);
        chk("beatLast", beatLast, exp_q[0].l);
        chk("beatParity", par_act, ^exp_q[0].d);
      end else begin
        chk("idle_beatData", beatData, 0);
        chk("idle_beatLast", beatLast, 0);
        chk("idle_beatParity", par_act, 0);
      end
      cap_pop = exp_pop;
      cap_hs  = (exp_q.size() != 0) && beatReady;
      if (beatValid && beatReady)
        obs.push_back('{d: beatData, l: beatLast, p: par_act, cyc: cyc});
      if (fifoRead) pop_cyc.push_back(cyc);
    end
  end

  always @(negedge rstb) exp_q.delete();

  always @(posedge clk) begin
    logic          p, h;
    logic [DW-1:0] rec;
    logic [95:0]   ext;
    p = cap_pop;
    h = cap_hs;
    cap_pop = 1'b0;
    cap_hs  = 1'b0;
    #1;
    if (rstb) begin
      if (h && exp_q.size() != 0) void'(exp_q.pop_front());
      if (p && fifo_q.size() != 0) begin
        rec = fifo_q.pop_front();
        ext = 96'(rec);
        for (int i = 0; i < NB; i++)
          exp_q.push_back('{d: ext[i*BW +: BW], l: (i == NB - 1)});
        refresh();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_obs(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin
      step();
      k++;
    end
    if (obs.size() < n) chk({nm, "_timeout"}, obs.size(), n);
  endtask

  localparam logic [DW-1:0] REC_A = {27'h5A5A5A5, 32'hCAFEBABE, 32'h12345678};
  localparam logic [DW-1:0] REC_B = {27'h0000123, 32'h0BADF00D, 32'hDEADBEEF};
  localparam logic [DW-1:0] REC_P = {27'h0, 32'h00000003, 32'h00000001};

  initial begin
    logic [95:0] rnd;
    int          k;

    repeat (3) step();
    rstb = 1'b1;
    beatReady = 1'b1;

    // Idle with empty FIFO
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("empty_fifoRead", fifoRead, 0);
      chk("empty_beatValid", beatValid, 0);
    end
    step();

    // Single record
    obs.delete();
    push_rec(REC_A);
    wait_obs(3, 20, "single");
    if (obs.size() >= 3) begin
      chk("single_b0", obs[0].d, 32'h12345678);
      chk("single_b1", obs[1].d, 32'hCAFEBABE);
      chk("single_b2", obs[2].d, 32'h05A5A5A5);
      chk("single_last", {obs[0].l, obs[1].l, obs[2].l}, 3'b001);
      chk("single_consec", obs[2].cyc - obs[0].cyc, 2);
    end
    @(negedge clk);
    chk("single_idle_after", beatValid, 0);
    step();

    // Two records back to back
    obs.delete();
    pop_cyc.delete();
    push_rec(REC_A);
    push_rec(REC_B);
    wait_obs(6, 30, "two");
    if (obs.size() >= 6) begin
      chk("two_consec", obs[5].cyc - obs[0].cyc, 5);
      chk("two_last", {obs[0].l, obs[1].l, obs[2].l, obs[3].l, obs[4].l, obs[5].l}, 6'b001001);
      chk("two_b3", obs[3].d, 32'hDEADBEEF);
      chk("two_b5", obs[5].d, 32'h00000123);
      chk("two_pops", pop_cyc.size(), 2);
      if (pop_cyc.size() == 2) begin
        chk("two_pop_gap", pop_cyc[1] - pop_cyc[0], 3);
        chk("two_first_beat_lat", obs[0].cyc - pop_cyc[0], 1);
      end
    end
    repeat (3) step();

    // Downstream stall during beat 1
    obs.delete();
    push_rec(REC_A);
    wait_obs(1, 20, "stall");
    beatReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_data", beatData, 32'hCAFEBABE);
      chk("stall_fifoRead", fifoRead, 0);
      chk("stall_valid", beatValid, 1);
    end
    step();
    beatReady = 1'b1;
    wait_obs(3, 20, "stall_resume");
    if (obs.size() >= 3) begin
      chk("stall_b1", obs[1].d, 32'hCAFEBABE);
      chk("stall_b2", obs[2].d, 32'h05A5A5A5);
    end
    repeat (3) step();

    // Reset in the middle of a record
    obs.delete();
    push_rec(REC_A);
    wait_obs(1, 20, "rst_mid");
    push_rec(REC_B);
    rstb = 1'b0;
    #1;
    chk("rst_mid_valid", beatValid, 0);
    chk("rst_mid_fifoRead", fifoRead, 0);
    step();
    rstb = 1'b1;
    obs.delete();
    @(negedge clk);
    chk("rst_rel_pop", fifoRead, 1);
    wait_obs(1, 10, "rst_rel");
    if (obs.size() >= 1) chk("rst_rel_b0", obs[0].d, 32'hDEADBEEF);
    repeat (4) step();

    // Parity pattern
    obs.delete();
    push_rec(REC_P);
    wait_obs(3, 20, "par");
    if (obs.size() >= 3) begin
      chk("par_b0_data", obs[0].d, 32'h00000001);
      chk("par_b1_data", obs[1].d, 32'h00000003);
      chk("par_b0", obs[0].p, 1);
      chk("par_b1", obs[1].p, 0);
    end
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      beatReady = ($urandom_range(3) != 0);
      if (fifo_q.size() < 4 && $urandom_range(2) == 0) begin
        rnd = {$urandom(), $urandom(), $urandom()};
        push_rec(rnd[DW-1:0]);
      end
      if (i == 400) rstb = 1'b0;
      if (i == 402) rstb = 1'b1;
      step();
    end
    beatReady = 1'b1;
    k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < 100) begin
      step();
      k++;
    end
    chk("drain_done", (fifo_q.size() != 0 || exp_q.size() != 0), 0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
